// File: rtl/kernel_cache_request_bridge.sv
// Bridges single-beat engine requests onto the cache S0 AXI4 slave port and returns R/B in one response slot.
// Optional KERNEL_CACHE_BRIDGE_STATS_EN adds AR / AW+W issue counters on stat_reads / stat_writes.
module kernel_cache_request_bridge #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               ap_clk,
    input  logic                               areset,
    input  logic                               cache_setup_signal,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic [DATA_W-1:0]                  req_wdata,
    input  logic [DATA_W/8-1:0]                req_wstrb,
    input  logic [ID_W-1:0]                    req_id,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic                               resp_write,
    output logic [DATA_W-1:0]                  resp_rdata,
    output logic [ID_W-1:0]                    resp_id,
    output logic                               resp_err,
    output logic                               arvalid,
    input  logic                               arready,
    output logic [ADDR_W-1:0]                  araddr,
    output logic [ID_W-1:0]                    arid,
    output logic [7:0]                         arlen,
    output logic [2:0]                         arsize,
    output logic [1:0]                         arburst,
    input  logic                               rvalid,
    output logic                               rready,
    input  logic [DATA_W-1:0]                  rdata,
    input  logic [ID_W-1:0]                    rid,
    input  logic [1:0]                         rresp,
    input  logic                               rlast,
    output logic                               awvalid,
    input  logic                               awready,
    output logic [ADDR_W-1:0]                  awaddr,
    output logic [ID_W-1:0]                    awid,
    output logic [7:0]                         awlen,
    output logic [2:0]                         awsize,
    output logic [1:0]                         awburst,
    output logic                               wvalid,
    input  logic                               wready,
    output logic [DATA_W-1:0]                  wdata,
    output logic [DATA_W/8-1:0]                wstrb,
    output logic                               wlast,
    input  logic                               bvalid,
    output logic                               bready,
    input  logic [ID_W-1:0]                    bid,
    input  logic [1:0]                         bresp,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_count,
    output logic                               busy,
    output logic [31:0]                        stat_reads,
    output logic [31:0]                        stat_writes
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        SETUP,
        IDLE,
        READ_ADDR,
        WRITE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                setup_low_seen;
    logic                accept;
    logic                issue;
    logic                retire;
    logic                slot_free;
    logic                aw_done;
    logic                w_done;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [ID_W-1:0]     id_q;
    logic                unused_inputs;

    assign unused_inputs = ^{rlast, rresp[0], bresp[0], req_addr[OFF_W-1:0]};

    assign arlen   = '0;
    assign awlen   = '0;
    assign arsize  = 3'(OFF_W);
    assign awsize  = 3'(OFF_W);
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arid    = id_q;
    assign awid    = id_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = wvalid;

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        arvalid    = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        case (state)
            SETUP: begin
                if (!cache_setup_signal && setup_low_seen)
                    state_next = IDLE;
            end
            IDLE: begin
                if (cache_setup_signal) begin
                    state_next = SETUP;
                end else begin
                    req_ready = (outstanding_count < MAX_CNT);
                    accept    = req_valid && (outstanding_count < MAX_CNT);
                    if (accept)
                        state_next = req_write ? WRITE : READ_ADDR;
                end
            end
            READ_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    issue      = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                // AW and W retire independently; the write is issued once both are through
                if ((aw_done || awready) && (w_done || wready)) begin
                    issue      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = SETUP;
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state          <= SETUP;
            setup_low_seen <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            id_q           <= '0;
        end else begin
            state          <= state_next;
            setup_low_seen <= (state == SETUP) && !cache_setup_signal;
            if (accept) begin
                addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                id_q    <= req_id;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (state == WRITE) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end
        end
    end

    // R has priority over B when both arrive while the slot can take one
    assign slot_free = !resp_valid || resp_ready;
    assign rready    = slot_free;
    assign bready    = slot_free && !rvalid;
    assign retire    = resp_valid && resp_ready;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else if (rvalid && rready) begin
            resp_valid <= 1'b1;
            resp_write <= 1'b0;
            resp_rdata <= rdata;
            resp_id    <= rid;
            resp_err   <= rresp[1];
        end else if (bvalid && bready) begin
            resp_valid <= 1'b1;
            resp_write <= 1'b1;
            resp_rdata <= '0;
            resp_id    <= bid;
            resp_err   <= bresp[1];
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            outstanding_count <= '0;
        end else begin
            case ({issue, retire})
                2'b10: if (outstanding_count < MAX_CNT)
                           outstanding_count <= outstanding_count + 1'b1;
                2'b01: if (outstanding_count != '0)
                           outstanding_count <= outstanding_count - 1'b1;
                default: outstanding_count <= outstanding_count;
            endcase
        end
    end

    assign busy = (state != IDLE) || (outstanding_count != '0);

`ifdef KERNEL_CACHE_BRIDGE_STATS_EN
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else if (issue) begin
            if (state == READ_ADDR) stat_reads  <= stat_reads + 32'd1;
            else                    stat_writes <= stat_writes + 32'd1;
        end
    end
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
`endif

endmodule

// File: tb/tb_kernel_cache_request_bridge.sv
// Directed bench for kernel_cache_request_bridge: AXI-side responses feed a scoreboard queue
// that a negedge monitor drains against the response slot; cycle-exact checks cover the FSM.
module tb_kernel_cache_request_bridge;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 4;
    localparam int MAXO   = 8;
`ifdef KERNEL_CACHE_BRIDGE_STATS_EN
    localparam int EXP_READS  = 10;
    localparam int EXP_WRITES = 1;
`else
    localparam int EXP_READS  = 0;
    localparam int EXP_WRITES = 0;
`endif

    logic              ap_clk = 1'b0;
    logic              areset;
    logic              cache_setup_signal;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic [ID_W-1:0]   req_id;
    logic              resp_valid, resp_ready, resp_write, resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic [ID_W-1:0]   resp_id;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready, wlast;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [3:0]        outstanding_count;
    logic              busy;
    logic [31:0]       stat_reads, stat_writes;

    kernel_cache_request_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ap_clk(ap_clk), .areset(areset), .cache_setup_signal(cache_setup_signal),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_id(resp_id), .resp_err(resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .outstanding_count(outstanding_count), .busy(busy),
        .stat_reads(stat_reads), .stat_writes(stat_writes)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic              w;
        logic [DATA_W-1:0] d;
        logic [ID_W-1:0]   id;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id, input logic err);
        exp_t e;
        e.w = w; e.d = d; e.id = id; e.err = err;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    task automatic send_req(input logic w, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_id = id;
        req_wdata = d; req_wstrb = '1;
    endtask

    // Scoreboard monitor: a response handshake completes on the following posedge
    always @(negedge ap_clk) begin
        if (!areset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0h with nothing expected", resp_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_popped++;
                check("sb_write", DATA_W'(resp_write), DATA_W'(e.w));
                check("sb_data",  resp_rdata,          e.d);
                check("sb_id",    DATA_W'(resp_id),    DATA_W'(e.id));
                check("sb_err",   DATA_W'(resp_err),   DATA_W'(e.err));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_w;
    logic [DATA_W-1:0] held_data;

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_w  = {16{32'hDEAD_0001}};
        areset = 1'b1; cache_setup_signal = 1'b1;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_id = '0;
        resp_ready = 1'b1;
        arready = 0; rvalid = 0; rdata = '0; rid = '0; rresp = '0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
        tick(); tick();
        check("rst_req_ready", DATA_W'(req_ready), '0);
        check("rst_count", DATA_W'(outstanding_count), '0);
        check("rst_valids", DATA_W'({arvalid, awvalid, wvalid, resp_valid}), '0);
        check("rst_araddr", DATA_W'(araddr), '0);
        areset = 1'b0;

        // Cache initialising: no request acceptance, then ready two cycles after the drop
        for (int i = 0; i < 20; i++) begin
            tick();
            check("setup_req_ready", DATA_W'(req_ready), '0);
        end
        cache_setup_signal = 1'b0;
        tick();
        check("setup_drop_1cyc", DATA_W'(req_ready), '0);
        tick();
        check("setup_drop_2cyc", DATA_W'(req_ready), 1);
        check("idle_busy", DATA_W'(busy), '0);

        // Single read with arready held off one cycle
        send_req(1'b0, 64'h1047, 4'd3, '0);
        tick();
        req_valid = 1'b0;
        check("rd_arvalid", DATA_W'(arvalid), 1);
        check("rd_araddr", DATA_W'(araddr), DATA_W'(64'h1040));
        check("rd_arsize", DATA_W'(arsize), 6);
        check("rd_arlen", DATA_W'(arlen), 0);
        check("rd_arburst", DATA_W'(arburst), 1);
        check("rd_arid", DATA_W'(arid), 3);
        tick();
        check("rd_ar_hold", DATA_W'({arvalid, araddr}), DATA_W'({1'b1, 64'h1040}));
        check("rd_count0", DATA_W'(outstanding_count), 0);
        arready = 1'b1;
        tick();
        check("rd_count1", DATA_W'(outstanding_count), 1);
        check("rd_ar_drop", DATA_W'(arvalid), 0);
        rvalid = 1'b1; rdata = pat_a5; rid = 4'd3; rresp = 2'b00; rlast = 1'b1;
        push(1'b0, pat_a5, 4'd3, 1'b0);
        tick();
        rvalid = 1'b0;
        check("rd_resp_valid", DATA_W'(resp_valid), 1);
        check("rd_count_held", DATA_W'(outstanding_count), 1);
        tick();
        check("rd_count_back0", DATA_W'(outstanding_count), 0);

        // Write: W accepted at once, AW accepted three cycles later, SLVERR back
        wready = 1'b1;
        send_req(1'b1, 64'h2000, 4'd5, pat_w);
        tick();
        req_valid = 1'b0;
        check("wr_both_valid", DATA_W'({awvalid, wvalid}), DATA_W'(2'b11));
        check("wr_wdata", wdata, pat_w);
        check("wr_wstrb", DATA_W'(wstrb), DATA_W'({64{1'b1}}));
        check("wr_wlast", DATA_W'(wlast), 1);
        check("wr_awaddr", DATA_W'(awaddr), DATA_W'(64'h2000));
        tick();
        check("wr_w_dropped", DATA_W'({awvalid, wvalid}), DATA_W'(2'b10));
        tick();
        check("wr_aw_waiting", DATA_W'({awvalid, wvalid}), DATA_W'(2'b10));
        check("wr_count0", DATA_W'(outstanding_count), 0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("wr_aw_dropped", DATA_W'(awvalid), 0);
        check("wr_count1", DATA_W'(outstanding_count), 1);
        bvalid = 1'b1; bid = 4'd5; bresp = 2'b10;
        push(1'b1, '0, 4'd5, 1'b1);
        tick();
        bvalid = 1'b0;
        tick();
        check("wr_count_back0", DATA_W'(outstanding_count), 0);

        // Fill to MAX_OUTSTANDING reads
        for (int i = 0; i < MAXO; i++) begin
            send_req(1'b0, 64'(i * 64), 4'(i), '0);
            tick();
            req_valid = 1'b0;
            tick();
            check("fill_count", DATA_W'(outstanding_count), DATA_W'(i + 1));
        end
        check("full_req_ready", DATA_W'(req_ready), 0);
        send_req(1'b0, 64'h9000, 4'hF, '0);
        tick();
        req_valid = 1'b0;
        check("full_no_accept", DATA_W'({arvalid, outstanding_count}), DATA_W'({1'b0, 4'd8}));
        for (int j = 0; j < MAXO; j++) begin
            rvalid = 1'b1; rdata = {16{32'h1000_0000 + 32'(j)}}; rid = 4'(j); rresp = 2'(j % 4);
            push(1'b0, {16{32'h1000_0000 + 32'(j)}}, 4'(j), (j % 4) >= 2);
            tick();
            if (j == 0) begin
                check("full_count_cap", DATA_W'(outstanding_count), 8);
                check("full_still_blocked", DATA_W'(req_ready), 0);
            end
            if (j == 1) begin
                check("full_count_dec", DATA_W'(outstanding_count), 7);
                check("full_ready_again", DATA_W'(req_ready), 1);
            end
        end
        rvalid = 1'b0;
        tick();
        check("drain_count0", DATA_W'(outstanding_count), 0);

        // Simultaneous R and B with the slot stalled; both spurious at count 0
        resp_ready = 1'b0;
        rvalid = 1'b1; rdata = {8{64'h0123_4567_89AB_CDEF}}; rid = 4'd9; rresp = 2'b11;
        bvalid = 1'b1; bid = 4'd10; bresp = 2'b00;
        held_data = {8{64'h0123_4567_89AB_CDEF}};
        push(1'b0, held_data, 4'd9, 1'b1);
        #1;
        check("rb_rready", DATA_W'(rready), 1);
        check("rb_bready_blocked", DATA_W'(bready), 0);
        tick();
        rvalid = 1'b0;
        check("rb_r_captured", DATA_W'({resp_valid, resp_write, resp_id}), DATA_W'({1'b1, 1'b0, 4'd9}));
        tick();
        check("rb_hold_data", resp_rdata, held_data);
        check("rb_hold_id", DATA_W'({resp_valid, resp_id}), DATA_W'({1'b1, 4'd9}));
        check("rb_bready_stall", DATA_W'(bready), 0);
        resp_ready = 1'b1;
        push(1'b1, '0, 4'd10, 1'b0);
        #1;
        check("rb_bready_open", DATA_W'(bready), 1);
        tick();
        bvalid = 1'b0;
        tick();
        check("rb_count_stays0", DATA_W'(outstanding_count), 0);
        check("rb_slot_empty", DATA_W'(resp_valid), 0);

        // Reset in the middle of a write
        send_req(1'b0, 64'h3000, 4'd1, '0);
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_count", DATA_W'(outstanding_count), 1);
        check("stat_reads", DATA_W'(stat_reads), DATA_W'(EXP_READS));
        check("stat_writes", DATA_W'(stat_writes), DATA_W'(EXP_WRITES));
        wready = 1'b0;
        send_req(1'b1, 64'h4000, 4'd2, pat_w);
        tick();
        req_valid = 1'b0;
        tick();
        check("pre_rst_awvalid", DATA_W'(awvalid), 1);
        areset = 1'b1;
        #1;
        check("rst_mid_valids", DATA_W'({arvalid, awvalid, wvalid, resp_valid}), '0);
        check("rst_mid_count", DATA_W'(outstanding_count), 0);
        check("rst_mid_setup", DATA_W'({req_ready, busy}), DATA_W'(2'b01));
        check("rst_mid_stats", DATA_W'({stat_reads, stat_writes}), '0);
        tick();
        areset = 1'b0;
        tick();
        tick();
        check("post_rst_ready", DATA_W'(req_ready), 1);
        tick();
        tick();

        check("sb_all_delivered", DATA_W'(n_popped), DATA_W'(n_pushed));
        check("sb_queue_empty", DATA_W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
